ht_seq_trojan: RTL and testbench

Parametrised sequential hardware-Trojan insertion cell for building benchmark netlists with stealthier Trojans than combinational taps. It sits on one or more victim nets of a host circuit and passes them through unchanged. It corrupts them only after a masked trigger pattern on a set of tapped host nets has been seen THRESH times. The payload then runs either permanently or for a bounded burst. A test-visible status port lets detection benches confirm activation.

---
 rtl/ht_seq_trojan_pkg.sv | 33 +++
 rtl/ht_seq_trojan_if.sv | 30 +++
 rtl/ht_seq_trojan_match_counter.sv | 52 +++++
 rtl/ht_seq_trojan.sv | 118 +++++++++++
 tb/tb_ht_seq_trojan.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ht_seq_trojan_pkg.sv
// Shared definitions for the sequential Trojan insertion cell.
//   ht_state_e     : trigger FSM states
//   HT_*           : payload mode encodings for the MODE parameter
//   ht_payload_bit : per-bit payload function applied to a victim net
package ht_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } ht_state_e;

  localparam logic [1:0] HT_FORCE0    = 2'd0;
  localparam logic [1:0] HT_FORCE1    = 2'd1;
  localparam logic [1:0] HT_INVERT    = 2'd2;
  localparam logic [1:0] HT_FORCE1_B0 = 2'd3;

  // Corrupted value of one victim bit; is_b0 marks victim bit 0, which is the
  // only bit touched in HT_FORCE1_B0 mode.
  function automatic logic ht_payload_bit(input logic [1:0] mode,
                                          input logic       is_b0,
                                          input logic       v);
    logic r;
    case (mode)
      HT_FORCE0: r = 1'b0;
      HT_FORCE1: r = 1'b1;
      HT_INVERT: r = ~v;
      default:   r = is_b0 ? 1'b1 : v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ht_seq_trojan_if.sv
// Host-side bundle of the Trojan cell.
//   en        : qualifies trigger sampling
//   trig_in   : tapped host nets
//   vic_in    : victim nets from the host
//   vic_out   : victim nets back to the host (possibly corrupted)
//   fired     : payload active (registered)
//   match_cnt : current trigger match count (registered)
// master = host side driving taps and victims, slave = the Trojan cell.
interface ht_seq_trojan_if #(
  parameter int N_TRIG = 4,
  parameter int N_PAY  = 1,
  parameter int CNT_W  = 8
);
  logic              en;
  logic [N_TRIG-1:0] trig_in;
  logic [N_PAY-1:0]  vic_in;
  logic [N_PAY-1:0]  vic_out;
  logic              fired;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output en, trig_in, vic_in,
    input  vic_out, fired, match_cnt
  );

  modport slave (
    input  en, trig_in, vic_in,
    output vic_out, fired, match_cnt
  );
endinterface

// File: rtl/ht_seq_trojan_match_counter.sv
// Masked trigger compare and bounded match counter.
//   clk, rst   : clock, synchronous active-high reset
//   en         : sampling qualifier; low holds the count
//   trig_in    : tapped host nets
//   freeze     : hold the count (payload active)
//   clr        : clear the count (burst expiry)
//   match/miss : qualified compare result this cycle
//   hit_thresh : this match is the THRESH-th one
//   cnt        : registered match count
module ht_match_counter #(
  parameter int                N_TRIG    = 4,
  parameter logic [N_TRIG-1:0] TRIG_VAL  = 4'b1111,
  parameter logic [N_TRIG-1:0] TRIG_MASK = 4'b1111,
  parameter int                CNT_W     = 8,
  parameter int                THRESH    = 255,
  parameter int                CONSEC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_TRIG-1:0] trig_in,
  input  logic              freeze,
  input  logic              clr,
  output logic              match,
  output logic              miss,
  output logic              hit_thresh,
  output logic [CNT_W-1:0]  cnt
);

  logic [CNT_W:0] cnt_nxt;

  assign match   = en && ((trig_in & TRIG_MASK) == (TRIG_VAL & TRIG_MASK));
  assign miss    = en && !match;
  // One extra bit so the compare is exact even at THRESH = 2^CNT_W-1.
  assign cnt_nxt = {1'b0, cnt} + 1'b1;
  assign hit_thresh = match && !freeze && (cnt_nxt == (CNT_W+1)'(THRESH));

  // The count stops at THRESH because the FSM freezes it once FIRE is entered,
  // so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (match) begin
        cnt <= cnt_nxt[CNT_W-1:0];
      end else if (miss && CONSEC != 0) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ht_seq_trojan.sv
// Sequential hardware-Trojan insertion cell. Victim nets pass straight through
// until a masked trigger pattern has been seen THRESH times; the registered
// fired flag then gates a MODE payload onto the victims, either until reset
// (BURST = 0) or for exactly BURST enabled cycles.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : ht_seq_trojan_if.slave (en, trig_in, vic_in in; vic_out, fired,
//         match_cnt out)
module ht_seq_trojan
  import ht_pkg::*;
#(
  parameter int                N_TRIG    = 4,
  parameter int                N_PAY     = 1,
  parameter logic [N_TRIG-1:0] TRIG_VAL  = 4'b1111,
  parameter logic [N_TRIG-1:0] TRIG_MASK = 4'b1111,
  parameter int                CNT_W     = 8,
  parameter int                THRESH    = 255,
  parameter int                CONSEC    = 0,
  parameter int                MODE      = 3,
  parameter int                BURST     = 0
) (
  input  logic            clk,
  input  logic            rst,
  ht_seq_trojan_if.slave  bus
);

  localparam int TMR_W = (BURST > 1) ? $clog2(BURST + 1) : 1;

  ht_state_e         state;
  logic              fired;
  logic [TMR_W-1:0]  timer;
  logic              match;
  logic              miss;
  logic              hit_thresh;
  logic              expire;
  logic [CNT_W-1:0]  cnt;

  // The expiry edge clears the counter and drops the payload; any match seen
  // in that same cycle is swallowed because the counter is still frozen.
  assign expire = (state == FIRE) && (BURST != 0) && bus.en && (timer == TMR_W'(1));

  ht_match_counter #(
    .N_TRIG    (N_TRIG),
    .TRIG_VAL  (TRIG_VAL),
    .TRIG_MASK (TRIG_MASK),
    .CNT_W     (CNT_W),
    .THRESH    (THRESH),
    .CONSEC    (CONSEC)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .trig_in    (bus.trig_in),
    .freeze     (state == FIRE),
    .clr        (expire),
    .match      (match),
    .miss       (miss),
    .hit_thresh (hit_thresh),
    .cnt        (cnt)
  );

  // The timer is loaded with BURST on entry; fired stays high through the
  // cycle in which it reads 1, giving exactly BURST active cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fired <= 1'b0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_thresh) begin
            state <= FIRE;
            fired <= 1'b1;
            timer <= TMR_W'(BURST);
          end else if (match) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (hit_thresh) begin
            state <= FIRE;
            fired <= 1'b1;
            timer <= TMR_W'(BURST);
          end else if (miss && CONSEC != 0) begin
            state <= IDLE;
          end
        end
        FIRE: begin
          if (expire) begin
            state <= IDLE;
            fired <= 1'b0;
          end else if (bus.en && BURST != 0) begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          fired <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency victim path; only the registered fired flag gates it.
  always_comb begin
    bus.vic_out = bus.vic_in;
    if (fired) begin
      for (int i = 0; i < N_PAY; i++) begin
        bus.vic_out[i] = ht_payload_bit(2'(MODE), (i == 0), bus.vic_in[i]);
      end
    end
  end

  assign bus.fired     = fired;
  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_ht_seq_trojan.sv
module tb_ht_seq_trojan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // A: defaults (THRESH 255, cumulative, sticky, MODE 3)
  ht_seq_trojan_if #(.N_TRIG(4), .N_PAY(1), .CNT_W(8)) ia ();
  ht_seq_trojan #(.N_TRIG(4), .N_PAY(1), .TRIG_VAL(4'b1111), .TRIG_MASK(4'b1111),
                  .CNT_W(8), .THRESH(255), .CONSEC(0), .MODE(3), .BURST(0))
    dut_a (.clk(clk), .rst(rst), .bus(ia));

  // B: consecutive, THRESH 3
  ht_seq_trojan_if #(.N_TRIG(4), .N_PAY(1), .CNT_W(8)) ib ();
  ht_seq_trojan #(.N_TRIG(4), .N_PAY(1), .TRIG_VAL(4'b1111), .TRIG_MASK(4'b1111),
                  .CNT_W(8), .THRESH(3), .CONSEC(1), .MODE(3), .BURST(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  // C: THRESH 1, burst of 4, invert
  ht_seq_trojan_if #(.N_TRIG(4), .N_PAY(1), .CNT_W(8)) ic ();
  ht_seq_trojan #(.N_TRIG(4), .N_PAY(1), .TRIG_VAL(4'b1111), .TRIG_MASK(4'b1111),
                  .CNT_W(8), .THRESH(1), .CONSEC(0), .MODE(2), .BURST(4))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  // D: masked compare, THRESH 2, force-1 on a 2-bit victim
  ht_seq_trojan_if #(.N_TRIG(4), .N_PAY(2), .CNT_W(8)) id ();
  ht_seq_trojan #(.N_TRIG(4), .N_PAY(2), .TRIG_VAL(4'b0001), .TRIG_MASK(4'b0011),
                  .CNT_W(8), .THRESH(2), .CONSEC(0), .MODE(1), .BURST(0))
    dut_d (.clk(clk), .rst(rst), .bus(id));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.en = 1'b0; ia.trig_in = 4'b0000; ia.vic_in = 1'b1;
    ib.en = 1'b0; ib.trig_in = 4'b0000; ib.vic_in = 1'b0;
    ic.en = 1'b0; ic.trig_in = 4'b0000; ic.vic_in = 1'b1;
    id.en = 1'b0; id.trig_in = 4'b0000; id.vic_in = 2'b00;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    check("a_rst_fired", 32'(ia.fired), 32'd0);
    check("a_rst_cnt",   32'(ia.match_cnt), 32'd0);
    check("a_rst_vic",   32'(ia.vic_out), 32'd1);
    check("c_rst_fired", 32'(ic.fired), 32'd0);

    // ---- A: 5 matches, then en low with toggling taps
    ia.en = 1'b1; ia.trig_in = 4'b1111; ia.vic_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("a_cnt5", 32'(ia.match_cnt), 32'd5);
    ia.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ia.trig_in = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      step();
    end
    check("a_enlow_cnt",   32'(ia.match_cnt), 32'd5);
    check("a_enlow_fired", 32'(ia.fired), 32'd0);
    // a miss after en-low must not clear a cumulative count
    ia.en = 1'b1; ia.trig_in = 4'b0000;
    step();
    check("a_miss_hold", 32'(ia.match_cnt), 32'd5);
    ia.trig_in = 4'b1111;
    for (int i = 0; i < 249; i++) step();
    check("a_cnt254",   32'(ia.match_cnt), 32'd254);
    check("a_fired254", 32'(ia.fired), 32'd0);
    check("a_vic254",   32'(ia.vic_out), 32'd0);
    step();
    check("a_fired255", 32'(ia.fired), 32'd1);
    check("a_vic255",   32'(ia.vic_out), 32'd1);
    check("a_cnt255",   32'(ia.match_cnt), 32'd255);
    step();
    check("a_sticky",     32'(ia.fired), 32'd1);
    check("a_cnt_nowrap", 32'(ia.match_cnt), 32'd255);
    // rst during the second FIRE cycle, with a match also present
    rst = 1'b1;
    step();
    rst = 1'b0;
    ia.en = 1'b0;
    #1;
    check("a_postrst_fired", 32'(ia.fired), 32'd0);
    check("a_postrst_cnt",   32'(ia.match_cnt), 32'd0);
    check("a_postrst_vic0",  32'(ia.vic_out), 32'd0);
    ia.vic_in = 1'b1;
    #1;
    check("a_postrst_vic1",  32'(ia.vic_out), 32'd1);

    // ---- B: consecutive pattern 1,1,0,1,1,1
    begin
      logic [5:0] pat;
      int         exp_cnt [6];
      int         exp_fir [6];
      pat = 6'b111011;  // bit i = sample i (LSB first)
      exp_cnt = '{1, 2, 0, 1, 2, 3};
      exp_fir = '{0, 0, 0, 0, 0, 1};
      ib.en = 1'b1;
      for (int i = 0; i < 6; i++) begin
        ib.trig_in = pat[i] ? 4'b1111 : 4'b0000;
        step();
        check($sformatf("b_cnt%0d", i), 32'(ib.match_cnt), 32'(exp_cnt[i]));
        check($sformatf("b_fired%0d", i), 32'(ib.fired), 32'(exp_fir[i]));
      end
      check("b_vic", 32'(ib.vic_out), 32'd1);
      ib.en = 1'b0;
    end

    // ---- C: single match, burst of 4, match in the expiry cycle
    ic.en = 1'b1; ic.trig_in = 4'b1111; ic.vic_in = 1'b1;
    step();
    check("c_fired1", 32'(ic.fired), 32'd1);
    check("c_vic1",   32'(ic.vic_out), 32'd0);
    ic.trig_in = 4'b0000;
    step();
    check("c_fired2", 32'(ic.fired), 32'd1);
    step();
    check("c_fired3", 32'(ic.fired), 32'd1);
    step();
    check("c_fired4", 32'(ic.fired), 32'd1);
    check("c_vic4",   32'(ic.vic_out), 32'd0);
    ic.trig_in = 4'b1111;  // match in the expiry cycle
    step();
    check("c_expired_fired", 32'(ic.fired), 32'd0);
    check("c_expired_cnt",   32'(ic.match_cnt), 32'd0);
    check("c_expired_vic",   32'(ic.vic_out), 32'd1);
    ic.trig_in = 4'b0000;
    step();
    check("c_after_fired", 32'(ic.fired), 32'd0);
    ic.en = 1'b0;

    // ---- D: masked compare
    id.en = 1'b1; id.trig_in = 4'b1110; id.vic_in = 2'b00;
    step();
    check("d_nomatch_cnt", 32'(id.match_cnt), 32'd0);
    id.trig_in = 4'b1101;
    step();
    check("d_match_cnt", 32'(id.match_cnt), 32'd1);
    check("d_fired0",    32'(id.fired), 32'd0);
    step();
    check("d_fired1", 32'(id.fired), 32'd1);
    check("d_vic",    32'(id.vic_out), 32'd3);
    id.en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
